// File: rtl/sobel_window_gen.sv
// 3x3 sliding-window generator for a raster pixel stream, using two line buffers; latency 1, no backpressure.
// Define SOBEL_BORDER_ZERO_EN to emit a window for every pixel, with taps that fall outside the frame forced to zero.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_pixel,
  output logic [7:0] pixel0,
  output logic [7:0] pixel1,
  output logic [7:0] pixel2,
  output logic [7:0] pixel3,
  output logic [7:0] pixel4,
  output logic [7:0] pixel5,
  output logic [7:0] pixel6,
  output logic [7:0] pixel7,
  output logic [7:0] pixel8,
  output logic       win_valid
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col, eff_col;
  logic [RW-1:0] row, eff_row;
  logic [7:0]    lb0 [IMG_WIDTH];
  logic [7:0]    lb1 [IMG_WIDTH];
  logic [7:0]    win [9];
  logic [7:0]    nxt [9];
  logic [7:0]    pix [9];

  // A start-of-frame pixel is (0,0) no matter where the counters had got to.
  assign eff_col = in_sof ? '0 : col;
  assign eff_row = in_sof ? '0 : row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (eff_col == COL_LAST) begin
        col <= '0;
        row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
      end else begin
        col <= eff_col + 1'b1;
        row <= eff_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb0[eff_col] <= lb1[eff_col];
      lb1[eff_col] <= in_pixel;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nxt[3*r]     = win[3*r+1];
      nxt[3*r+1]   = win[3*r+2];
      nxt[3*r+2]   = 8'h00;
    end
    nxt[2] = lb0[eff_col];
    nxt[5] = lb1[eff_col];
    nxt[8] = in_pixel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) win[k] <= 8'h00;
    end else if (in_valid) begin
      for (int k = 0; k < 9; k++) win[k] <= nxt[k];
    end
  end

`ifdef SOBEL_BORDER_ZERO_EN
  logic [7:0] out_q [9];
  logic [2:0] row_ok, col_ok;

  // Index 0 is the oldest row/column of the window, two steps behind the current pixel.
  always_comb begin
    row_ok = {1'b1, eff_row >= RW'(1), eff_row >= RW'(2)};
    col_ok = {1'b1, eff_col >= CW'(1), eff_col >= CW'(2)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) out_q[k] <= 8'h00;
      win_valid <= 1'b0;
    end else begin
      win_valid <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < 9; k++)
          out_q[k] <= (row_ok[k/3] && col_ok[k%3]) ? nxt[k] : 8'h00;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++) pix[k] = out_q[k];
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_valid <= 1'b0;
    else     win_valid <= in_valid && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
  end

  always_comb begin
    for (int k = 0; k < 9; k++) pix[k] = win[k];
  end
`endif

  assign pixel0 = pix[0];
  assign pixel1 = pix[1];
  assign pixel2 = pix[2];
  assign pixel3 = pix[3];
  assign pixel4 = pix[4];
  assign pixel5 = pix[5];
  assign pixel6 = pix[6];
  assign pixel7 = pix[7];
  assign pixel8 = pix[8];

endmodule
